// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a standard-mode FIFO into a 3-entry buffer and presents it as a valid/ready stream
module fifo_rd_stream #(
   parameter int DW = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fifo_empty,
   output logic          fifo_rd_en,
   input  logic [DW-1:0] fifo_dout,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic [CW-1:0] cnt
);
   logic          r_run;
   logic          r_inflight;
   logic [DW-1:0] r_buf [3];
   logic [1:0]    r_wptr;
   logic [1:0]    r_rptr;
   logic [1:0]    r_occ;
   logic [CW-1:0] r_cnt;
   logic          w_pop;

   // reads are gated by registered occupancy plus the word in flight, so m_ready never reaches fifo_rd_en
   always_comb begin
      fifo_rd_en = r_run & ~fifo_empty & (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3);
      m_valid    = r_occ != 2'd0;
      m_data     = r_buf[r_rptr];
      w_pop      = m_valid & m_ready;
      cnt        = r_cnt;
   end

   // control state; reset discards buffered and in-flight words at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run      <= 1'b0;
         r_inflight <= 1'b0;
         r_wptr     <= 2'd0;
         r_rptr     <= 2'd0;
         r_occ      <= 2'd0;
         r_cnt      <= '0;
      end else begin
         r_run      <= 1'b1;
         r_inflight <= fifo_rd_en;
         if (r_inflight)
            r_wptr <= (r_wptr == 2'd2) ? 2'd0 : r_wptr + 2'd1;
         if (w_pop) begin
            r_rptr <= (r_rptr == 2'd2) ? 2'd0 : r_rptr + 2'd1;
            r_cnt  <= r_cnt + CW'(1);
         end
         if (r_inflight != w_pop)
            r_occ <= r_inflight ? r_occ + 2'd1 : r_occ - 2'd1;
      end
   end

   // capture the word returned one cycle after each read; storage needs no reset
   always_ff @(posedge clk) begin
      if (r_inflight)
         r_buf[r_wptr] <= fifo_dout;
   end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: vector table, directed corner cases and randomized traffic against a queue model
module tb_fifo_rd_stream;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_empty = 1'b1;
   logic        m_ready = 1'b0;
   logic [7:0]  fifo_dout = 8'h00;
   logic        fifo_rd_en, m_valid, rd_en4, m_valid4;
   logic [7:0]  m_data, m_data4;
   logic [15:0] cnt;
   logic [3:0]  cnt4;

   fifo_rd_stream #(.DW(8), .CW(16)) dut (
      .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_dout(fifo_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .cnt(cnt)
   );

   fifo_rd_stream #(.DW(8), .CW(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en4),
      .fifo_dout(fifo_dout), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .cnt(cnt4)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mem [256];
   int         ri = 0;
   int         wi = 0;
   logic [7:0] expq [$];
   int         cnt_m = 0;
   int         nrel = 0;
   logic       last_rd = 1'b0;
   logic       rd_s = 1'b0;
   logic       hs_s = 1'b0;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        e_rd;
      logic        e_vld;
      logic [7:0]  e_dat;
      logic [15:0] e_cnt;
   } vec_t;
   vec_t tbl [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: every word read is queued; a read is allowed while fewer than 3 words are read but undelivered
   task automatic mchk();
      int   sz;
      int   cap;
      logic e_rd;
      sz   = expq.size();
      cap  = sz - int'(last_rd);
      e_rd = rst_n && nrel >= 1 && !fifo_empty && sz < 3;
      chk("rd_en", fifo_rd_en, e_rd);
      chk("rd_en4", rd_en4, e_rd);
      chk("valid", m_valid, cap > 0);
      chk("valid4", m_valid4, cap > 0);
      if (cap > 0) begin
         chk("data", m_data, expq[0]);
         chk("data4", m_data4, expq[0]);
      end
      chk("cnt", cnt, cnt_m[15:0]);
      chk("cnt4", cnt4, cnt_m[3:0]);
   endtask

   task automatic model_reset();
      expq.delete();
      cnt_m   = 0;
      nrel    = 0;
      last_rd = 1'b0;
      rd_s    = 1'b0;
      hs_s    = 1'b0;
   endtask

   task automatic cycle(input logic rst, input logic rdy, input logic bub);
      @(posedge clk);
      #1;
      if (rst_n) begin
         if (rd_s) begin
            fifo_dout = mem[ri];
            expq.push_back(mem[ri]);
            ri++;
         end
         if (hs_s && expq.size() > 0) begin
            void'(expq.pop_front());
            cnt_m++;
         end
         last_rd = rd_s;
         if (nrel < 2) nrel++;
      end
      rst_n = rst;
      if (!rst) model_reset();
      m_ready    = rdy;
      fifo_empty = (ri >= wi) | bub;
      @(negedge clk);
      mchk();
      rd_s = fifo_rd_en;
      hs_s = m_valid & m_ready;
   endtask

   task automatic load(input int n);
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      ri = 0;
      wi = n;
   endtask

   initial begin
      int   first, last, pops, k;
      logic found;
      logic [7:0] nxt;
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 16'd0};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 16'd0};
      tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 16'd1};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 16'd2};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 16'd3};
      tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 16'd4};

      // reset with data available, first read and fill latency, short backpressure
      load(256);
      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].rst, tbl[i].rdy, 1'b0);
         chk($sformatf("tbl%0d_rd", i), fifo_rd_en, tbl[i].e_rd);
         chk($sformatf("tbl%0d_vld", i), m_valid, tbl[i].e_vld);
         if (tbl[i].e_vld) chk($sformatf("tbl%0d_dat", i), m_data, tbl[i].e_dat);
         chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].e_cnt);
      end

      // full-rate stream of 64 words, with the 4-bit counter wrapping
      cycle(1'b0, 1'b0, 1'b0);
      load(64);
      cycle(1'b0, 1'b0, 1'b0);
      first = -1;
      last  = -1;
      for (int i = 0; i < 200; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         if (hs_s) begin
            if (first < 0) first = i;
            last = i;
         end
         if (cnt_m == 16) chk("wrap16", cnt4, 0);
         if (cnt_m == 17) chk("wrap17", cnt4, 1);
         if (cnt_m == 64) break;
      end
      chk("fr_nogap", last - first, 63);
      chk("fr_cnt", cnt, 64);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         chk("fr_idle_rd", fifo_rd_en, 0);
      end

      // backpressure: three reads, then a stable head word for 20+ cycles
      cycle(1'b0, 1'b0, 1'b0);
      load(256);
      pops = 0;
      for (int i = 0; i < 25; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         pops += int'(rd_s);
         if (i >= 4) begin
            chk("bp_vld", m_valid, 1);
            chk("bp_dat", m_data, 8'h00);
            chk("bp_rd", fifo_rd_en, 0);
         end
      end
      chk("bp_pops", pops, 3);
      k = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         chk("bp_drain_vld", m_valid, 1);
         chk("bp_drain_dat", m_data, 8'(k));
         k++;
      end

      // asynchronous reset pulse with two words buffered and one in flight
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (expq.size() == 3 && last_rd) begin
            found = 1'b1;
            break;
         end
      end
      chk("mid_state_reached", found, 1);
      nxt = mem[ri];
      #2 rst_n = 1'b0;
      #1;
      chk("mid_vld", m_valid, 0);
      chk("mid_rd", fifo_rd_en, 0);
      chk("mid_cnt", cnt, 0);
      chk("mid_cnt4", cnt4, 0);
      model_reset();
      #1 rst_n = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         if (m_valid) begin
            found = 1'b1;
            chk("mid_next_word", m_data, nxt);
            break;
         end
      end
      chk("mid_valid_seen", found, 1);

      // bubbled source and random sink, 256 words
      cycle(1'b0, 1'b0, 1'b0);
      load(256);
      for (int i = 0; i < 6000; i++) begin
         cycle(1'b1, 1'($urandom % 2), 1'($urandom % 2));
         if (cnt_m == 256) break;
      end
      chk("rnd_cnt", cnt, 256);
      chk("rnd_cnt4", cnt4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
